// File: rtl/dyn_dist_pkg.sv
// Shared types and helpers for the dynamic-node 1:8 ejection distributor.
package dyn_dist_pkg;

    localparam int unsigned DEST_W     = 3;
    localparam int unsigned NUM_OUT    = 8;
    localparam int unsigned FLIT_MAX_W = 1024;
    localparam int unsigned IDX_W      = $clog2(FLIT_MAX_W);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } dist_state_t;

    // Callers zero-extend their flit to FLIT_MAX_W so one helper serves any WIDTH.
    function automatic logic [DEST_W-1:0] get_dest(input logic [FLIT_MAX_W-1:0] flit,
                                                   input logic [IDX_W-1:0]      lsb);
        return flit[lsb +: DEST_W];
    endfunction

    function automatic logic [31:0] get_len(input logic [FLIT_MAX_W-1:0] flit,
                                            input logic [IDX_W-1:0]      lsb);
        return flit[lsb +: 32];
    endfunction

    function automatic logic [NUM_OUT-1:0] onehot(input logic [DEST_W-1:0] d);
        return NUM_OUT'(1) << d;
    endfunction

endpackage

// File: rtl/dist_credit_cnt.sv
// Per-output saturating credit counter driven by yummy returns and sends.
module dist_credit_cnt #(
    parameter int unsigned CREDITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero
);

    localparam int unsigned CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt;

    // A simultaneous return and send cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= FULL;
        end else if (inc && !dec) begin
            if (cnt != FULL) begin
                cnt <= cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign nonzero = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst_n && inc && !dec) begin
            assert (cnt != FULL)
            else $warning("dist_credit_cnt: yummy returned while counter already at %0d", CREDITS);
        end
    end

endmodule

// File: rtl/one_to_eight_dist.sv
// Packet demultiplexer: routes each packet from one flit stream to one of eight
// credit-controlled outputs, holding the header's destination for the whole packet.
module one_to_eight_dist
    import dyn_dist_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEST_LSB = 0,
    parameter int unsigned LEN_LSB  = 3,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CREDITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   yummy_in
);

    dist_state_t         state, state_nxt;
    logic [DEST_W-1:0]   dest_q, dest_nxt;
    logic [LEN_W-1:0]    remaining, remaining_nxt;

    logic [DEST_W-1:0]   hdr_dest;
    logic [LEN_W-1:0]    hdr_len;
    logic [DEST_W-1:0]   target;
    logic [NUM_OUT-1:0]  credit_nz;
    logic [NUM_OUT-1:0]  send;
    logic                accept;

    assign hdr_dest = get_dest(FLIT_MAX_W'(in_data), IDX_W'(DEST_LSB));
    assign hdr_len  = LEN_W'(get_len(FLIT_MAX_W'(in_data), IDX_W'(LEN_LSB)));

    // In IDLE the incoming flit is the header, so it steers itself.
    assign target   = (state == IDLE) ? hdr_dest : dest_q;
    assign in_ready = credit_nz[target];
    assign accept   = in_valid && in_ready;
    assign send     = accept ? onehot(target) : '0;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_credit
        dist_credit_cnt #(
            .CREDITS (CREDITS)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (yummy_in[i]),
            .dec     (send[i]),
            .nonzero (credit_nz[i])
        );
    end

    always_comb begin
        state_nxt     = state;
        dest_nxt      = dest_q;
        remaining_nxt = remaining;
        unique case (state)
            IDLE: begin
                if (accept && (hdr_len != '0)) begin
                    dest_nxt      = hdr_dest;
                    remaining_nxt = hdr_len;
                    state_nxt     = BODY;
                end
            end
            BODY: begin
                if (accept) begin
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dest_q    <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            dest_q    <= dest_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= send;
            if (accept) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_one_to_eight_dist.sv
// Directed bench for one_to_eight_dist: vector table plus reset and credit-overflow sequences.
module tb_one_to_eight_dist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  yummy_in;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [63:0] last_od = '0;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  y;
        logic        er;
        logic [7:0]  eov;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    one_to_eight_dist #(
        .WIDTH    (64),
        .DEST_LSB (0),
        .LEN_LSB  (3),
        .LEN_W    (8),
        .CREDITS  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .yummy_in  (yummy_in)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [63:0] mk(input logic [15:0] tag, input logic [2:0] dest,
                                       input logic [7:0] len);
        return {tag, 37'd0, len, dest};
    endfunction

    function automatic logic [63:0] bd(input logic [15:0] tag, input logic [2:0] lowdest);
        return {tag, 45'd0, lowdest};
    endfunction

    function automatic void add(input logic v, input logic [63:0] d, input logic [7:0] y,
                                input logic er, input logic [7:0] eov, input string nm);
        tbl.push_back('{v, d, y, er, eov, nm});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the following negedge with outputs checked.
    task automatic apply(input logic v, input logic [63:0] d, input logic [7:0] y,
                         input logic er, input logic [7:0] eov, input string nm);
        in_valid = v;
        in_data  = d;
        yummy_in = y;
        #1;
        chk({nm, ".ready"}, 64'(in_ready), 64'(er));
        @(negedge clk);
        if (eov != 8'h00) last_od = d;
        chk({nm, ".ov"}, 64'(out_valid), 64'(eov));
        chk({nm, ".od"}, out_data, last_od);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        yummy_in = '0;

        // Header to 5 with two body flits, then drain and restore credit 5.
        add(1, mk(16'd1, 3'd5, 8'd2), 8'h00, 1, 8'h20, "a1_hdr5");
        add(1, bd(16'd2, 3'd1),       8'h00, 1, 8'h20, "a2_body");
        add(1, bd(16'd3, 3'd1),       8'h00, 1, 8'h20, "a3_body");
        add(1, mk(16'd4, 3'd5, 8'd0), 8'h00, 1, 8'h20, "a4_last_credit");
        add(1, mk(16'd5, 3'd5, 8'd0), 8'h00, 0, 8'h00, "a5_starved");
        add(0, mk(16'd5, 3'd5, 8'd0), 8'h20, 0, 8'h00, "a6_yummy");
        add(0, mk(16'd5, 3'd5, 8'd0), 8'h20, 1, 8'h00, "a7_yummy");
        add(0, mk(16'd5, 3'd5, 8'd0), 8'h20, 1, 8'h00, "a8_yummy");
        add(0, mk(16'd5, 3'd5, 8'd0), 8'h20, 1, 8'h00, "a9_yummy");
        // Back-to-back header-only packets.
        add(1, mk(16'd6, 3'd3, 8'd0), 8'h00, 1, 8'h08, "b1_hdr3");
        add(1, mk(16'd7, 3'd6, 8'd0), 8'h00, 1, 8'h40, "b2_hdr6");
        add(1, mk(16'd8, 3'd1, 8'd0), 8'h00, 1, 8'h02, "b3_hdr1");
        add(0, 64'd0,                 8'h4A, 1, 8'h00, "b4_restore");
        // Dest 0, length 5: stalls after four credits, resumes on yummy.
        add(1, mk(16'd9, 3'd0, 8'd5), 8'h00, 1, 8'h01, "c1_hdr0");
        add(1, bd(16'd10, 3'd4),      8'h00, 1, 8'h01, "c2_body");
        add(1, bd(16'd11, 3'd4),      8'h00, 1, 8'h01, "c3_body");
        add(1, bd(16'd12, 3'd4),      8'h00, 1, 8'h01, "c4_body");
        add(1, bd(16'd13, 3'd4),      8'h00, 0, 8'h00, "c5_stall");
        add(1, bd(16'd13, 3'd4),      8'h00, 0, 8'h00, "c6_stall");
        add(1, bd(16'd13, 3'd4),      8'h01, 0, 8'h00, "c7_yummy_no_bypass");
        add(1, bd(16'd13, 3'd4),      8'h01, 1, 8'h01, "c8_send_and_yummy");
        add(1, bd(16'd14, 3'd4),      8'h00, 1, 8'h01, "c9_last_body");
        add(1, mk(16'd15, 3'd2, 8'd0), 8'h00, 1, 8'h04, "c10_idle_again");
        // Dest 2: yummy and send in the same cycle at credit 1.
        add(1, mk(16'd16, 3'd2, 8'd0), 8'h00, 1, 8'h04, "d1_hdr2");
        add(1, mk(16'd17, 3'd2, 8'd0), 8'h00, 1, 8'h04, "d2_hdr2");
        add(1, mk(16'd18, 3'd2, 8'd0), 8'h04, 1, 8'h04, "d3_both");
        add(1, mk(16'd19, 3'd2, 8'd0), 8'h00, 1, 8'h04, "d4_still_ready");
        add(1, mk(16'd20, 3'd2, 8'd0), 8'h00, 0, 8'h00, "d5_empty");
        add(0, 64'd0,                 8'h05, 0, 8'h00, "d6_restore");
        add(0, 64'd0,                 8'h05, 1, 8'h00, "d7_restore");
        add(0, 64'd0,                 8'h05, 1, 8'h00, "d8_restore");
        add(0, 64'd0,                 8'h05, 1, 8'h00, "d9_restore");

        repeat (2) @(negedge clk);
        chk("reset.ov", 64'(out_valid), 64'h0);
        chk("reset.od", out_data, 64'h0);
        chk("reset.ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].er, tbl[i].eov, tbl[i].nm);
        end

        // Asynchronous reset in the middle of a packet to dest 4.
        apply(1, mk(16'd21, 3'd4, 8'd4), 8'h00, 1, 8'h10, "e1_hdr4");
        apply(1, bd(16'd22, 3'd1),       8'h00, 1, 8'h10, "e2_body");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("e_async_rst.ov", 64'(out_valid), 64'h0);
        chk("e_async_rst.od", out_data, 64'h0);
        last_od = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, mk(16'd23, 3'd6, 8'd0), 8'h00, 1, 8'h40, "e3_header_after_rst");
        for (int k = 0; k < 4; k++) begin
            apply(1, mk(16'(24 + k), 3'd4, 8'd0), 8'h00, 1, 8'h10, "e4_full_credits");
        end
        apply(1, mk(16'd28, 3'd4, 8'd0), 8'h00, 0, 8'h00, "e5_credits_used");

        // Yummy to an already full counter must saturate at 4.
        apply(0, 64'd0, 8'h80, 1, 8'h00, "f1_overflow_yummy");
        for (int k = 0; k < 4; k++) begin
            apply(1, mk(16'(29 + k), 3'd7, 8'd0), 8'h00, 1, 8'h80, "f2_send7");
        end
        apply(1, mk(16'd33, 3'd7, 8'd0), 8'h00, 0, 8'h00, "f3_saturated");

        in_valid = 1'b0;
        yummy_in = '0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
